// File: rtl/dsp_mac_pkg.sv
`default_nettype none
// ============================================================================
// dsp_mac_pkg : shared constants, state encoding and tag type for dsp_mac_seq
// Rev 1.0     : initial release
// ============================================================================
package dsp_mac_pkg;

    // OPMODE codes for the dsp48a1 slice (pre-adder bypassed, add mode)
    localparam logic [7:0] c_opm_first = 8'h01;  // X=M, Z=0
    localparam logic [7:0] c_opm_acc   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] c_opm_hold  = 8'h08;  // X=0, Z=P

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_feed  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_out   = 2'd3;

    localparam int c_pipe_lat_def = 3;
    localparam int c_opm_dly_def  = 1;

    typedef struct packed {
        logic valid;
        logic first;
    } tag_t;

    function automatic logic [7:0] opm_decode(input tag_t t);
        if (t.first)
            return c_opm_first;
        else if (t.valid)
            return c_opm_acc;
        else
            return c_opm_hold;
    endfunction

endpackage : dsp_mac_pkg
`default_nettype wire

// File: rtl/dsp_tag_pipe.sv
`default_nettype none
// ============================================================================
// dsp_tag_pipe : PIPE_LAT-deep shift register of operand tags that tracks
//                each pair through the slice; exposes the OPMODE tap stage.
// Rev 1.0      : initial release
// ============================================================================
module dsp_tag_pipe
    import dsp_mac_pkg::*;
#(
    parameter int PIPE_LAT = c_pipe_lat_def,
    parameter int OPM_DLY  = c_opm_dly_def
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_tap,
    output logic final_valid,
    output logic upstream_valid
);

    // r_stage[i] holds the tag i+1 edges after its operands were registered
    tag_t r_stage [PIPE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++)
                r_stage[i] <= '0;
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT; i++)
                r_stage[i] <= r_stage[i-1];
        end
    end

    assign tag_tap     = r_stage[OPM_DLY-1];
    assign final_valid = r_stage[PIPE_LAT-1].valid;

    always_comb begin
        upstream_valid = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++)
            upstream_valid = upstream_valid | r_stage[i].valid;
    end

endmodule : dsp_tag_pipe
`default_nettype wire

// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// dsp_mac_seq : feeds LEN operand pairs into a dsp48a1 slice so PM accumulates
//               sum(A*B), then captures PM under a valid/ready handshake.
// Rev 1.0     : initial release
// ============================================================================
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = c_pipe_lat_def,
    parameter int OPM_DLY  = c_opm_dly_def
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [17:0] in_a,
    input  logic signed [17:0] in_b,
    output logic signed [17:0] dsp_a,
    output logic signed [17:0] dsp_b,
    output logic [7:0]         dsp_opmode,
    input  logic signed [47:0] dsp_pm,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [47:0] res_data
);

    logic [1:0]         r_state;
    logic [LEN_W-1:0]   r_count;
    logic               r_first;
    logic signed [17:0] r_dsp_a;
    logic signed [17:0] r_dsp_b;
    tag_t               r_in_tag;
    logic               r_res_valid;
    logic signed [47:0] r_res_data;

    logic w_accept;
    tag_t w_push;
    tag_t w_tap;
    logic w_final_valid;
    logic w_upstream_valid;
    logic w_last_out;

    assign w_accept     = (r_state == c_st_feed) && in_valid;
    assign w_push.valid = w_accept;
    assign w_push.first = w_accept && r_first;

    // r_in_tag travels alongside dsp_a/dsp_b; the pipe adds the slice latency
    dsp_tag_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .OPM_DLY  (OPM_DLY)
    ) u_tag_pipe (
        .clk            (clk),
        .rst_n          (rst_n),
        .tag_in         (r_in_tag),
        .tag_tap        (w_tap),
        .final_valid    (w_final_valid),
        .upstream_valid (w_upstream_valid)
    );

    // No pushes happen in DRAIN, so a lone valid tag at the end is the last one
    assign w_last_out = w_final_valid && !w_upstream_valid && !r_in_tag.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_count     <= '0;
            r_first     <= 1'b0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_in_tag    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_in_tag <= w_push;
            case (r_state)
                c_st_idle: begin
                    if (start && (len != '0)) begin
                        r_count <= len;
                        r_first <= 1'b1;
                        r_state <= c_st_feed;
                    end
                end
                c_st_feed: begin
                    if (in_valid) begin
                        r_dsp_a <= in_a;
                        r_dsp_b <= in_b;
                        r_first <= 1'b0;
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1))
                            r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (w_last_out) begin
                        r_res_data  <= dsp_pm;
                        r_res_valid <= 1'b1;
                        r_state     <= c_st_out;
                    end
                end
                c_st_out: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy       = (r_state != c_st_idle);
    assign in_ready   = (r_state == c_st_feed);
    assign dsp_a      = r_dsp_a;
    assign dsp_b      = r_dsp_b;
    assign dsp_opmode = opm_decode(w_tap);
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;

endmodule : dsp_mac_seq
`default_nettype wire
